reg_file_seq: RTL and testbench
===============================

Name: reg_file_seq

Overview:
Multi-cycle sequencer that drives the control inputs of the in-array compute register file (cell-array datapath) for one decoded instruction at a time. It accepts an instruction over a valid/ready handshake and steps through per-class states. It handles the memory request/acknowledge for loads and stores and samples the per-row overflow vector to resolve branches. It sits between the instruction decoder and the register file; immediate and PC values go directly from the decoder to the register file.

Parameters:
ROWS, 32, register count; width of ovf_check.
MEM_TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting (1..255).

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
instr_valid  in  1  decoded instruction available
instr_ready  out  1  sequencer can accept an instruction
opclass  in  3  0 ALU_RR, 1 ALU_RI, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 AUIPC
funct  in  4  one-hot op_fa code (0001 add, 0010 and, 0100 xor, 1000 or)
br_ne  in  1  branch sense: 1 = BNE, 0 = BEQ
rd, rs1, rs2  in  5 each  register indices
rd_index, rs1_index, rs2_index  out  5 each  latched indices to the register file
write_en, op_enable, data2bus_en, exp_go_up, exp_go_dn, imm_en, dataFM_en, pc_plus_en, pc_imm_en, imm_up_en  out  1 each  register-file strobes
op_fa  out  4  full-adder operation select
mem_req  out  1  memory request; held until mem_ack
mem_we  out  1  1 = store, 0 = load; valid while mem_req is high
mem_ack  in  1  memory completion
ovf_check  in  ROWS  per-row carry/overflow vector from the register file
br_valid  out  1  one-cycle pulse; br_taken is valid in that cycle
br_taken  out  1  branch resolution
done  out  1  one-cycle pulse at instruction retire
err  out  1  one-cycle pulse on memory timeout (replaces done)

Behaviour:
- Reset: state IDLE. All outputs 0, except instr_ready = 1. Index registers and the timeout counter are 0. Reset asserted mid-instruction aborts it at once; no done or err pulse is produced.
- Handshake: an instruction is accepted on the cycle where instr_valid and instr_ready are both high. opclass, funct, br_ne, rd, rs1, rs2 are latched in that cycle. instr_ready is 1 only in IDLE.
- All strobe outputs are registered and decoded from the next state. Each strobe is therefore high exactly during the named state, starting the cycle after the transition edge.
- Write suppression: write_en is forced to 0 whenever the latched rd == 0.
- States:
  - IDLE: on accept, go to OPND if ALU_RR, else EXEC.
  - OPND (ALU_RR only, 1 cycle): data2bus_en = 1, rs2 is driven. Next state EXEC.
  - EXEC, by class:
    - ALU_RR: op_enable, write_en, op_fa = funct.
    - ALU_RI: imm_en, op_enable, write_en, op_fa = funct.
    - LOAD / STORE: exp_go_up, op_enable, imm_en, op_fa = 0001. STORE also asserts data2bus_en. Next state MEM.
    - BRANCH: exp_go_dn, data2bus_en, op_fa = 0100. Next state BRES.
    - JAL: pc_plus_en, write_en.
    - LUI: imm_up_en, write_en.
    - AUIPC: pc_imm_en, write_en.
    - All other classes go to DONE after EXEC.
  - MEM: keep the EXEC strobes; assert mem_req, with mem_we = 1 for STORE.
    - On mem_ack: LOAD goes to WB, STORE goes to DONE.
    - The timeout counter increments every MEM cycle. When it reaches MEM_TIMEOUT without mem_ack, go to IDLE and pulse err.
    - mem_ack arriving in the same cycle the count reaches MEM_TIMEOUT counts as success.
  - WB (LOAD, 1 cycle): dataFM_en and write_en (write_en still subject to rd == 0 suppression). Next state DONE.
  - BRES (1 cycle): sample c = ovf_check[rs1_index]; br_taken = br_ne ? c : ~c; pulse br_valid. Next state DONE.
  - DONE (1 cycle): all strobes 0; pulse done. Next state IDLE.
- Latency from accept to done pulse:
  - ALU_RI, JAL, LUI, AUIPC: 3 cycles.
  - ALU_RR, BRANCH: 4 cycles.
  - STORE: 4 + memory wait cycles.
  - LOAD: 5 + memory wait cycles.
- mem_ack outside MEM is ignored. instr_valid outside IDLE is ignored (not accepted).

Decomposition:
- Shared package rf_ctrl_pkg holds:
  - the opclass enum;
  - the state enum (IDLE, OPND, EXEC, MEM, WB, BRES, DONE);
  - OP_FA_ADD / AND / XOR / OR constants;
  - a packed struct rf_ctrl_t bundling the ten strobes and op_fa.
- One combinational sub-module, rf_strobe_decode, maps (next state, opclass, funct, rd == 0) to rf_ctrl_t. The top level owns the FSM, latches, counter and handshake.

Test Plan:
- After reset release: instr_ready = 1, all strobes 0. ALU_RR add rd=3 rs1=1 rs2=2 -> data2bus_en one cycle, then op_enable + write_en with op_fa = 0001, done 4 cycles after accept.
- ALU_RI xor with rd=0 -> imm_en, op_enable, op_fa = 0100; write_en stays 0 throughout; done at cycle 3.
- LOAD rd=5 rs1=4, mem_ack after 2 wait cycles -> mem_req high for 3 cycles with mem_we = 0, then dataFM_en + write_en one cycle, done at cycle 7.
- STORE with mem_ack never asserted, MEM_TIMEOUT = 15 -> mem_req high 15 cycles, err pulses, no done, instr_ready returns the next cycle.
- BEQ rs1=6 with ovf_check[6] = 0 -> br_valid with br_taken = 1. Repeat as BNE with ovf_check[6] = 1 -> br_taken = 1.
- Reset pulled low during MEM of a LOAD -> outputs return to reset values immediately; a following JAL rd=1 completes with pc_plus_en + write_en and done at cycle 3.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file control sequencer: instruction classes,
// sequencer states, full-adder op codes and the strobe bundle.
package rf_ctrl_pkg;

    localparam int unsigned IDX_W = 5;
    localparam int unsigned FA_W  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        OC_ALU_RR = 3'd0,
        OC_ALU_RI = 3'd1,
        OC_LOAD   = 3'd2,
        OC_STORE  = 3'd3,
        OC_BRANCH = 3'd4,
        OC_JAL    = 3'd5,
        OC_LUI    = 3'd6,
        OC_AUIPC  = 3'd7
    } opclass_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPND = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_BRES = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    localparam logic [FA_W-1:0] OP_FA_ADD = 4'b0001;
    localparam logic [FA_W-1:0] OP_FA_AND = 4'b0010;
    localparam logic [FA_W-1:0] OP_FA_XOR = 4'b0100;
    localparam logic [FA_W-1:0] OP_FA_OR  = 4'b1000;

    typedef struct packed {
        logic            write_en;
        logic            op_enable;
        logic            data2bus_en;
        logic            exp_go_up;
        logic            exp_go_dn;
        logic            imm_en;
        logic            datafm_en;
        logic            pc_plus_en;
        logic            pc_imm_en;
        logic            imm_up_en;
        logic [FA_W-1:0] op_fa;
    } rf_ctrl_t;

endpackage

// File: rtl/rf_strobe_decode.sv
// Combinational map from (state being entered, instruction class, funct,
// rd==0) to the register-file strobe bundle.
module rf_strobe_decode
    import rf_ctrl_pkg::*;
(
    input  state_e          state_i,
    input  opclass_e        cls_i,
    input  logic [FA_W-1:0] funct_i,
    input  logic            rd_zero_i,
    output rf_ctrl_t        ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (state_i)
            ST_OPND: ctrl_c.data2bus_en = 1'b1;
            // MEM holds the address-generation strobes set up in EXEC
            ST_EXEC, ST_MEM: begin
                case (cls_i)
                    OC_ALU_RR: begin
                        ctrl_c.op_enable = 1'b1;
                        ctrl_c.write_en  = 1'b1;
                        ctrl_c.op_fa     = funct_i;
                    end
                    OC_ALU_RI: begin
                        ctrl_c.imm_en    = 1'b1;
                        ctrl_c.op_enable = 1'b1;
                        ctrl_c.write_en  = 1'b1;
                        ctrl_c.op_fa     = funct_i;
                    end
                    OC_LOAD, OC_STORE: begin
                        ctrl_c.exp_go_up   = 1'b1;
                        ctrl_c.op_enable   = 1'b1;
                        ctrl_c.imm_en      = 1'b1;
                        ctrl_c.op_fa       = OP_FA_ADD;
                        ctrl_c.data2bus_en = (cls_i == OC_STORE);
                    end
                    OC_BRANCH: begin
                        ctrl_c.exp_go_dn   = 1'b1;
                        ctrl_c.data2bus_en = 1'b1;
                        ctrl_c.op_fa       = OP_FA_XOR;
                    end
                    OC_JAL: begin
                        ctrl_c.pc_plus_en = 1'b1;
                        ctrl_c.write_en   = 1'b1;
                    end
                    OC_LUI: begin
                        ctrl_c.imm_up_en = 1'b1;
                        ctrl_c.write_en  = 1'b1;
                    end
                    OC_AUIPC: begin
                        ctrl_c.pc_imm_en = 1'b1;
                        ctrl_c.write_en  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                ctrl_c.datafm_en = 1'b1;
                ctrl_c.write_en  = 1'b1;
            end
            default: ;
        endcase
        // x0 is hard-wired zero
        if (rd_zero_i) ctrl_c.write_en = 1'b0;
    end

endmodule

// File: rtl/reg_file_seq.sv
// Multi-cycle sequencer driving the in-array compute register file for one
// decoded instruction at a time, including memory handshake and branch resolve.
module reg_file_seq
    import rf_ctrl_pkg::*;
#(
    parameter int unsigned ROWS        = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [2:0]      opclass,
    input  logic [3:0]      funct,
    input  logic            br_ne,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [4:0]      rd_index,
    output logic [4:0]      rs1_index,
    output logic [4:0]      rs2_index,
    output logic            write_en,
    output logic            op_enable,
    output logic            data2bus_en,
    output logic            exp_go_up,
    output logic            exp_go_dn,
    output logic            imm_en,
    output logic            dataFM_en,
    output logic            pc_plus_en,
    output logic            pc_imm_en,
    output logic            imm_up_en,
    output logic [3:0]      op_fa,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    input  logic [ROWS-1:0] ovf_check,
    output logic            br_valid,
    output logic            br_taken,
    output logic            done,
    output logic            err
);

    state_e           state_q, state_d;
    opclass_e         cls_q, cls_d;
    logic [FA_W-1:0]  funct_q, funct_d;
    logic             br_ne_q, br_ne_d;
    logic [IDX_W-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic             accept_c, timeout_c, ovf_bit_c;
    rf_ctrl_t         ctrl_c, ctrl_q;
    logic             instr_ready_q, mem_req_q, mem_we_q;
    logic             br_valid_q, br_taken_q, done_q, err_q;

    assign accept_c  = instr_valid && instr_ready_q;
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign ovf_bit_c = ovf_check[rs1_q];

    // Instruction fields: take the live inputs on the accept cycle so the
    // strobes registered at that edge already reflect the new instruction.
    always_comb begin
        cls_d   = cls_q;
        funct_d = funct_q;
        br_ne_d = br_ne_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        if (accept_c) begin
            cls_d   = opclass_e'(opclass);
            funct_d = funct;
            br_ne_d = br_ne;
            rd_d    = rd;
            rs1_d   = rs1;
            rs2_d   = rs2;
        end
    end

    // Next-state and memory-wait counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c)
                    state_d = (opclass_e'(opclass) == OC_ALU_RR) ? ST_OPND : ST_EXEC;
            end
            ST_OPND: state_d = ST_EXEC;
            ST_EXEC: begin
                cnt_d = '0;
                case (cls_q)
                    OC_LOAD, OC_STORE: state_d = ST_MEM;
                    OC_BRANCH:         state_d = ST_BRES;
                    default:           state_d = ST_DONE;
                endcase
            end
            ST_MEM: begin
                cnt_d = cnt_inc_c;
                // ack on the final allowed cycle still wins over timeout
                if (mem_ack) begin
                    state_d = (cls_q == OC_LOAD) ? ST_WB : ST_DONE;
                end else if (cnt_inc_c == CNT_W'(MEM_TIMEOUT)) begin
                    state_d   = ST_IDLE;
                    timeout_c = 1'b1;
                end
            end
            ST_WB:   state_d = ST_DONE;
            ST_BRES: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    rf_strobe_decode u_decode (
        .state_i   (state_d),
        .cls_i     (cls_d),
        .funct_i   (funct_d),
        .rd_zero_i (rd_d == '0),
        .ctrl_c    (ctrl_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cls_q         <= OC_ALU_RR;
            funct_q       <= '0;
            br_ne_q       <= 1'b0;
            rd_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            cnt_q         <= '0;
            ctrl_q        <= '0;
            instr_ready_q <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            br_valid_q    <= 1'b0;
            br_taken_q    <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            funct_q       <= funct_d;
            br_ne_q       <= br_ne_d;
            rd_q          <= rd_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            cnt_q         <= cnt_d;
            ctrl_q        <= ctrl_c;
            instr_ready_q <= (state_d == ST_IDLE);
            mem_req_q     <= (state_d == ST_MEM);
            mem_we_q      <= (state_d == ST_MEM) && (cls_d == OC_STORE);
            // overflow vector is settled during BRES, after the EXEC compare
            br_valid_q    <= (state_q == ST_BRES);
            br_taken_q    <= (state_q == ST_BRES) && (br_ne_q ? ovf_bit_c : !ovf_bit_c);
            done_q        <= (state_d == ST_DONE);
            err_q         <= timeout_c;
        end
    end

    assign instr_ready = instr_ready_q;
    assign rd_index    = rd_q;
    assign rs1_index   = rs1_q;
    assign rs2_index   = rs2_q;
    assign write_en    = ctrl_q.write_en;
    assign op_enable   = ctrl_q.op_enable;
    assign data2bus_en = ctrl_q.data2bus_en;
    assign exp_go_up   = ctrl_q.exp_go_up;
    assign exp_go_dn   = ctrl_q.exp_go_dn;
    assign imm_en      = ctrl_q.imm_en;
    assign dataFM_en   = ctrl_q.datafm_en;
    assign pc_plus_en  = ctrl_q.pc_plus_en;
    assign pc_imm_en   = ctrl_q.pc_imm_en;
    assign imm_up_en   = ctrl_q.imm_up_en;
    assign op_fa       = ctrl_q.op_fa;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign br_valid    = br_valid_q;
    assign br_taken    = br_taken_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_reg_file_seq.sv
// Randomized self-checking bench for reg_file_seq: per-instruction strobe
// cycle counts, latency and branch outcome against a behavioural model.
module tb_reg_file_seq;

    localparam int unsigned MEM_TO = 15;
    localparam int          NCNT   = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, instr_ready;
    logic [2:0]  opclass;
    logic [3:0]  funct;
    logic        br_ne;
    logic [4:0]  rd, rs1, rs2;
    logic [4:0]  rd_index, rs1_index, rs2_index;
    logic        write_en, op_enable, data2bus_en, exp_go_up, exp_go_dn, imm_en;
    logic        dataFM_en, pc_plus_en, pc_imm_en, imm_up_en;
    logic [3:0]  op_fa;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] ovf_check;
    logic        br_valid, br_taken, done, err;

    int n_checks = 0;
    int n_errors = 0;

    string cnt_name [NCNT] = '{"data2bus_en", "op_enable", "write_en", "imm_en", "exp_go_up",
                               "exp_go_dn", "dataFM_en", "pc_plus_en", "pc_imm_en", "imm_up_en",
                               "mem_req", "mem_we", "br_valid", "done", "err"};

    reg_file_seq #(.ROWS(32), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opclass(opclass), .funct(funct), .br_ne(br_ne),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .rd_index(rd_index), .rs1_index(rs1_index), .rs2_index(rs2_index),
        .write_en(write_en), .op_enable(op_enable), .data2bus_en(data2bus_en),
        .exp_go_up(exp_go_up), .exp_go_dn(exp_go_dn), .imm_en(imm_en),
        .dataFM_en(dataFM_en), .pc_plus_en(pc_plus_en), .pc_imm_en(pc_imm_en),
        .imm_up_en(imm_up_en), .op_fa(op_fa),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .ovf_check(ovf_check),
        .br_valid(br_valid), .br_taken(br_taken), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [20:0] outs();
        return {instr_ready, write_en, op_enable, data2bus_en, exp_go_up, exp_go_dn, imm_en,
                dataFM_en, pc_plus_en, pc_imm_en, imm_up_en, op_fa,
                mem_req, mem_we, br_valid, br_taken, done, err};
    endfunction

    // Issue one instruction; w = memory wait cycles before mem_ack (large = never).
    task automatic run_instr(input logic [2:0] cls, input logic [3:0] fn, input logic bne,
                             input logic [4:0] rd_v, input logic [4:0] rs1_v,
                             input logic [4:0] rs2_v, input logic [31:0] ovf, input int w);
        bit rr, ri, ld, st, br, jal, lui, aui, mem, to, fin;
        int m, lat, lat_exp, fa_bad, mseen;
        int cexp [NCNT];
        int cobs [NCNT];
        logic [3:0] fa_exp;
        logic brt_obs, brt_exp;
        rr = (cls == 3'd0); ri = (cls == 3'd1); ld = (cls == 3'd2); st = (cls == 3'd3);
        br = (cls == 3'd4); jal = (cls == 3'd5); lui = (cls == 3'd6); aui = (cls == 3'd7);
        mem = ld || st;
        m   = (w + 1 <= int'(MEM_TO)) ? w + 1 : int'(MEM_TO);
        to  = mem && (w + 1 > int'(MEM_TO));

        cexp[0]  = rr ? 1 : st ? 1 + m : br ? 1 : 0;
        cexp[1]  = (rr || ri) ? 1 : mem ? 1 + m : 0;
        cexp[2]  = (rd_v == 5'd0) ? 0 : (rr || ri || jal || lui || aui || (ld && !to)) ? 1 : 0;
        cexp[3]  = ri ? 1 : mem ? 1 + m : 0;
        cexp[4]  = mem ? 1 + m : 0;
        cexp[5]  = br ? 1 : 0;
        cexp[6]  = (ld && !to) ? 1 : 0;
        cexp[7]  = jal ? 1 : 0;
        cexp[8]  = aui ? 1 : 0;
        cexp[9]  = lui ? 1 : 0;
        cexp[10] = mem ? m : 0;
        cexp[11] = st ? m : 0;
        cexp[12] = br ? 1 : 0;
        cexp[13] = to ? 0 : 1;
        cexp[14] = to ? 1 : 0;
        fa_exp   = (rr || ri) ? fn : mem ? 4'b0001 : br ? 4'b0100 : 4'b0000;
        if (rr || br)      lat_exp = 4;
        else if (st)       lat_exp = 3 + m;
        else if (ld)       lat_exp = to ? 3 + m : 4 + m;
        else               lat_exp = 3;
        brt_exp = bne ? ovf[rs1_v] : !ovf[rs1_v];

        for (int i = 0; i < 50 && !instr_ready; i++) @(negedge clk);
        check("ready_before_issue", 32'(instr_ready), 32'd1);
        opclass = cls; funct = fn; br_ne = bne; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v;
        ovf_check = ovf; instr_valid = 1'b1; mem_ack = 1'b0;

        for (int i = 0; i < NCNT; i++) cobs[i] = 0;
        fin = 0; lat = 0; fa_bad = 0; mseen = 0; brt_obs = 1'bx;
        for (int k = 1; k <= 600 && !fin; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("ready_low_after_accept", 32'(instr_ready), 32'd0);
                check("latched_indices", 32'({rd_index, rs1_index, rs2_index}),
                      32'({rd_v, rs1_v, rs2_v}));
            end
            cobs[0]  += int'(data2bus_en); cobs[1]  += int'(op_enable);
            cobs[2]  += int'(write_en);    cobs[3]  += int'(imm_en);
            cobs[4]  += int'(exp_go_up);   cobs[5]  += int'(exp_go_dn);
            cobs[6]  += int'(dataFM_en);   cobs[7]  += int'(pc_plus_en);
            cobs[8]  += int'(pc_imm_en);   cobs[9]  += int'(imm_up_en);
            cobs[10] += int'(mem_req);     cobs[11] += int'(mem_we);
            cobs[12] += int'(br_valid);    cobs[13] += int'(done);
            cobs[14] += int'(err);
            if ((op_enable || exp_go_dn) ? (op_fa !== fa_exp) : (op_fa !== 4'b0000)) fa_bad++;
            if (br_valid) brt_obs = br_taken;
            if (done || err) begin
                fin = 1;
                lat = k + 1;
            end
            if (mem_req) begin
                mseen++;
                mem_ack = (mseen == w + 1);
            end else begin
                mem_ack = 1'($urandom);   // stray acks outside MEM must be ignored
            end
            if (instr_ready || fin) begin
                instr_valid = 1'b0;
            end else begin
                instr_valid = 1'($urandom);   // must not be accepted while busy
                opclass = 3'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
            end
        end
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        if (!fin) check("instr_finished", 32'd0, 32'd1);
        check("latency", 32'(lat), 32'(lat_exp));
        for (int i = 0; i < NCNT; i++) check({"cycles_", cnt_name[i]}, 32'(cobs[i]), 32'(cexp[i]));
        check("op_fa_bad_cycles", 32'(fa_bad), 32'd0);
        if (br) check("br_taken", 32'(brt_obs), 32'(brt_exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c;
        int         w;
        rst = 1'b0; instr_valid = 1'b0; opclass = '0; funct = '0; br_ne = 1'b0;
        rd = '0; rs1 = '0; rs2 = '0; mem_ack = 1'b0; ovf_check = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(outs()), 32'h0010_0000);
        check("reset_indices", 32'({rd_index, rs1_index, rs2_index}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", 32'(outs()), 32'h0010_0000);

        run_instr(3'd0, 4'b0001, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 0);          // ALU_RR add
        run_instr(3'd1, 4'b0100, 1'b0, 5'd0, 5'd7, 5'd8, 32'h0, 0);          // ALU_RI xor rd=0
        run_instr(3'd2, 4'b0000, 1'b0, 5'd5, 5'd4, 5'd0, 32'h0, 2);          // LOAD, 2 waits
        run_instr(3'd3, 4'b0000, 1'b0, 5'd0, 5'd4, 5'd9, 32'h0, 1000);       // STORE timeout
        run_instr(3'd3, 4'b0000, 1'b0, 5'd0, 5'd4, 5'd9, 32'h0, 14);         // ack on last cycle
        run_instr(3'd2, 4'b0000, 1'b0, 5'd2, 5'd4, 5'd0, 32'h0, 14);
        run_instr(3'd4, 4'b0000, 1'b0, 5'd0, 5'd6, 5'd1, 32'hFFFF_FFBF, 0);  // BEQ, c=0
        run_instr(3'd4, 4'b0000, 1'b1, 5'd0, 5'd6, 5'd1, 32'h0000_0040, 0);  // BNE, c=1

        // Reset pulled during MEM of a LOAD
        for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
        opclass = 3'd2; rd = 5'd5; rs1 = 5'd4; rs2 = 5'd0; instr_valid = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("in_mem_before_reset", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("reset_mid_mem_outputs", 32'(outs()), 32'h0010_0000);
        check("reset_mid_mem_indices", 32'({rd_index, rs1_index, rs2_index}), 32'd0);
        @(negedge clk);
        check("reset_held_outputs", 32'(outs()), 32'h0010_0000);
        rst = 1'b1;
        run_instr(3'd5, 4'b0000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0, 0);          // JAL rd=1

        for (int n = 0; n < 40; n++) begin
            c = 3'($urandom_range(0, 7));
            w = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 4));
            run_instr(c, 4'(4'b0001 << $urandom_range(0, 3)), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                      5'($urandom), 5'($urandom), $urandom, w);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
